// File: rtl/fetch_redirect_ctrl_pkg.sv
// rtl/fetch_redirect_ctrl_pkg.sv - shared defines for the fetch redirect controller
// Redirect FSM state encoding and redirect kind, shared with the PC stage.
package fetch_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_BR_WAIT_SLOT = 2'd1,
    ST_BR_PEND      = 2'd2,
    ST_EXC_PEND     = 2'd3
  } redir_state_e;

  typedef enum logic {
    REDIR_BR  = 1'b0,
    REDIR_EXC = 1'b1
  } redir_type_e;

  localparam logic [31:0] REDIR_PC_RST = 32'h0;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
// Clear wins over enable; the count sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// rtl/fetch_redirect_ctrl.sv - holds branch/exception redirects until IF can take them
// Issues one registered redirect pulse; exceptions preempt any held branch.
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             exc_req_i,
  input  logic [31:0]      exc_pc_i,
  input  logic             br_req_i,
  input  logic [31:0]      br_pc_i,
  input  logic             slot_done_i,
  input  logic             fetch_busy_i,
  output logic             redir_valid_o,
  output logic [31:0]      redir_pc_o,
  output logic             if_flush_o,
  output logic             pending_o,
  output logic [CNT_W-1:0] pend_cycles_o
);

  redir_state_e r_state;
  redir_type_e  r_type;
  logic [31:0]  r_tgt;
  logic         r_first;
  logic         r_valid;
  logic         r_flush;
  logic [31:0]  r_pc;

  logic             w_pending;
  logic             w_cnt_clr;
  logic [CNT_W-1:0] w_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_type  <= REDIR_BR;
      r_tgt   <= '0;
      r_first <= 1'b0;
      r_valid <= 1'b0;
      r_flush <= 1'b0;
      r_pc    <= REDIR_PC_RST;
    end else begin
      r_valid <= 1'b0;
      r_flush <= 1'b0;
      r_first <= 1'b0;
      if (exc_req_i) begin
        r_type <= REDIR_EXC;
        r_tgt  <= exc_pc_i;
        if (!fetch_busy_i) begin
          r_valid <= 1'b1;
          r_flush <= 1'b1;
          r_pc    <= exc_pc_i;
          r_state <= ST_IDLE;
        end else begin
          r_first <= 1'b1;
          r_state <= ST_EXC_PEND;
        end
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (br_req_i) begin
              r_type <= REDIR_BR;
              r_tgt  <= br_pc_i;
              if (slot_done_i && !fetch_busy_i) begin
                r_valid <= 1'b1;
                r_pc    <= br_pc_i;
              end else begin
                r_first <= 1'b1;
                r_state <= slot_done_i ? ST_BR_PEND : ST_BR_WAIT_SLOT;
              end
            end
          end
          // The branch must not leave before its delay slot has been accepted.
          ST_BR_WAIT_SLOT: begin
            if (slot_done_i) begin
              if (!fetch_busy_i) begin
                r_valid <= 1'b1;
                r_pc    <= r_tgt;
                r_state <= ST_IDLE;
              end else begin
                r_state <= ST_BR_PEND;
              end
            end
          end
          ST_BR_PEND, ST_EXC_PEND: begin
            if (!fetch_busy_i) begin
              r_valid <= 1'b1;
              r_flush <= (r_type == REDIR_EXC);
              r_pc    <= r_tgt;
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // First cycle of a fresh hold restarts the count, hiding any stale value.
  assign w_pending = (r_state != ST_IDLE);
  assign w_cnt_clr = !w_pending || r_first;

  sat_counter #(
    .W(CNT_W)
  ) u_pend_cnt (
    .i_clk (clk),
    .i_rst (rst),
    .i_clr (w_cnt_clr),
    .i_en  (!w_cnt_clr),
    .o_cnt (w_cnt)
  );

  assign redir_valid_o = r_valid;
  assign redir_pc_o    = r_pc;
  assign if_flush_o    = r_flush;
  assign pending_o     = w_pending;
  assign pend_cycles_o = (w_pending && !r_first) ? w_cnt : '0;

endmodule

// File: doc/fetch_redirect_ctrl.md
FETCH_REDIRECT_CTRL -- requirements
Module: fetch_redirect_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of the pending-cycle counter.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst  in  1  synchronous reset, active-high.
REQ-004 exc_req_i  in  1  exception/ERET flush request from the controller, one-cycle pulse.
REQ-005 exc_pc_i  in  32  exception target; valid with exc_req_i.
REQ-006 br_req_i  in  1  taken-branch request from ID, one-cycle pulse.
REQ-007 br_pc_i  in  32  branch target; valid with br_req_i.
REQ-008 slot_done_i  in  1  delay-slot instruction accepted into IF/ID this cycle.
REQ-009 fetch_busy_i  in  1  IF cannot accept a new PC this cycle (icache stall, axi stall, or if_stall).
REQ-010 redir_valid_o  out  1  one-cycle pulse: the PC stage loads redir_pc_o.
REQ-011 redir_pc_o  out  32  redirect target.
REQ-012 if_flush_o  out  1  kill the instruction in IF; pulses with exception redirects only.
REQ-013 pending_o  out  1  a redirect is held, not yet issued.
REQ-014 pend_cycles_o  out  CNT_W  cycles the current redirect has been held; saturating.

Function
REQ-015 The FSM SHALL have four states: IDLE, BR_WAIT_SLOT, BR_PEND, EXC_PEND.
REQ-016 Issue condition: a redirect is issuable in cycle N when its target is latched or presented and fetch_busy_i=0 in cycle N; redir_valid_o, redir_pc_o and if_flush_o are registered and SHALL appear in cycle N+1 for exactly one cycle.
REQ-017 Exception priority: exc_req_i in any state SHALL replace any held branch; if fetch_busy_i=0, issue in the same cycle and go to IDLE; otherwise latch exc_pc_i and go to EXC_PEND.
REQ-018 EXC_PEND: on fetch_busy_i=0, issue the latched target with if_flush_o=1 and go to IDLE; br_req_i and slot_done_i are ignored.
REQ-019 IDLE + br_req_i (no exc_req_i): latch br_pc_i; if slot_done_i=1 in the same cycle, handle as in BR_PEND in that cycle; otherwise go to BR_WAIT_SLOT.
REQ-020 BR_WAIT_SLOT: on slot_done_i=1, go to BR_PEND, or issue immediately if fetch_busy_i=0 in the same cycle; a branch is never issued before its delay slot is accepted.
REQ-021 BR_PEND: on fetch_busy_i=0, issue with if_flush_o=0 and go to IDLE.
REQ-022 br_req_i while in BR_WAIT_SLOT or BR_PEND SHALL be ignored (one branch in flight).
REQ-023 pending_o=1 in BR_WAIT_SLOT, BR_PEND and EXC_PEND; 0 in IDLE.
REQ-024 pend_cycles_o SHALL clear on entry to any pending state, increment by 1 each cycle the state stays pending, saturate at 2^CNT_W-1, and read 0 in IDLE.
REQ-025 When not pulsing, redir_valid_o=0 and if_flush_o=0, and redir_pc_o holds its last issued value.
REQ-026 Back-to-back case: a new request in the cycle after an issue SHALL be accepted normally (IDLE has no dead cycle).

Reset
REQ-027 Reset values: rst=1 SHALL force state IDLE, redir_valid_o=0, if_flush_o=0, pending_o=0, pend_cycles_o=0, redir_pc_o=32'h0, and all latched targets to 0.
REQ-028 Reset mid-operation SHALL discard any held redirect and issue no redirect pulse in the following cycle.
REQ-029 Reset SHALL take priority over all simultaneous requests.

Structure
REQ-030 The FSM state encoding and the redirect type (exception/branch) SHALL live in the shared CPU defines package alongside `ExcE.
REQ-031 The pending-cycle counter SHALL be a sub-module named sat_counter (parameterised width, clear, enable).
REQ-032 The PC stage SHALL consume redir_valid_o and redir_pc_o in place of its internal branch and exception hold registers.

Verification
REQ-033 Branch with delay slot ready: br_req_i=1, br_pc_i=32'hbfc00100, slot_done_i=1, fetch_busy_i=0 in cycle 0 -> cycle 1: redir_valid_o=1, redir_pc_o=32'hbfc00100, if_flush_o=0.
REQ-034 Branch then stall: br_req_i in cycle 0, slot_done_i in cycle 2, fetch_busy_i=1 in cycles 0-5 -> pending_o=1 in cycles 1-6, pend_cycles_o=4 in cycle 6, redirect pulse in cycle 7.
REQ-035 Exception overrides branch: branch held in BR_PEND with fetch_busy_i=1; exc_req_i with exc_pc_i=32'hbfc00380 -> state EXC_PEND; once busy drops, a single pulse to 32'hbfc00380 with if_flush_o=1, and the branch target is never issued.
REQ-036 Simultaneous requests: exc_req_i=1 and br_req_i=1 in the same cycle, fetch_busy_i=0 -> only the exception target is issued, next cycle.
REQ-037 Reset mid-pend: EXC_PEND, then rst=1 for 1 cycle -> no redir_valid_o pulse; all outputs at reset values.
REQ-038 Saturation: CNT_W=4, fetch_busy_i held high for 20 cycles in BR_PEND -> pend_cycles_o stops at 15.
